// File: rtl/frame_scheduler.sv
// frame_scheduler
//   Double-buffer sequencer between the rasterizer and the frame/depth buffers.
//   It allows drawing into the back buffer. When the rasterizer reports a
//   finished frame, it waits for vertical blanking and swaps front and back.
//   It then streams a clear pass (clear colour and far depth) over the new back
//   buffer before drawing resumes.
//
// Ports
//   clk_system      : system clock, the only clock
//   rstn_system     : synchronous active-low reset
//   frame_end_valid : rasterizer finished the current frame
//   frame_end_ready : frame-end accepted (RENDER only)
//   vblank_pulse    : one-cycle start-of-vblank pulse, already in clk_system
//   render_enable   : rasterizer may write the back buffer
//   active_buffer   : index of the displayed (front) buffer
//   clr_m_*         : clear-pass write stream (valid/ready, addr, buffer, data)
//   frame_count     : completed swaps, wraps at 16 bits
//   busy            : high in every state except RENDER
module frame_scheduler #(
  parameter int unsigned            PIXEL_COUNT = 76800,
  parameter int unsigned            ADDR_WIDTH  = 17,
  parameter int unsigned            COLOR_WIDTH = 12,
  parameter int unsigned            DEPTH_WIDTH = 16,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0,
  parameter logic [DEPTH_WIDTH-1:0] CLEAR_DEPTH = '1
) (
  input  logic                   clk_system,
  input  logic                   rstn_system,
  input  logic                   frame_end_valid,
  output logic                   frame_end_ready,
  input  logic                   vblank_pulse,
  output logic                   render_enable,
  output logic                   active_buffer,
  output logic                   clr_m_valid,
  input  logic                   clr_m_ready,
  output logic [ADDR_WIDTH-1:0]  clr_m_addr,
  output logic                   clr_m_buffer,
  output logic [COLOR_WIDTH-1:0] clr_m_color,
  output logic [DEPTH_WIDTH-1:0] clr_m_depth,
  output logic [15:0]            frame_count,
  output logic                   busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXEL_COUNT - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_CLEAR,
    ST_RENDER,
    ST_WAIT_VBLANK,
    ST_SWAP
  } state_t;

  state_t state;
  state_t state_next;

  logic clr_fire;
  logic clr_last;

  assign clr_fire = (state == ST_CLEAR) && clr_m_ready;
  assign clr_last = (clr_m_addr == LAST_ADDR);

  always_ff @(posedge clk_system) begin
    if (!rstn_system) begin
      state         <= ST_INIT;
      clr_m_addr    <= '0;
      active_buffer <= 1'b0;
      frame_count   <= '0;
    end else begin
      state <= state_next;
      // The address wraps to 0 on the final transfer, so it is already 0
      // whenever the FSM is outside CLEAR.
      if (clr_fire) begin
        clr_m_addr <= clr_last ? '0 : clr_m_addr + ADDR_WIDTH'(1);
      end
      if (state == ST_SWAP) begin
        active_buffer <= ~active_buffer;
        frame_count   <= frame_count + 16'd1;
        clr_m_addr    <= '0;
      end
    end
  end

  always_comb begin
    state_next      = state;
    clr_m_valid     = 1'b0;
    render_enable   = 1'b0;
    frame_end_ready = 1'b0;
    busy            = 1'b1;
    case (state)
      ST_INIT: begin
        state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr_m_valid = 1'b1;
        if (clr_fire && clr_last) begin
          state_next = ST_RENDER;
        end
      end
      ST_RENDER: begin
        render_enable   = 1'b1;
        frame_end_ready = 1'b1;
        busy            = 1'b0;
        if (frame_end_valid) begin
          state_next = ST_WAIT_VBLANK;
        end
      end
      ST_WAIT_VBLANK: begin
        // A pulse that coincides with the frame-end handshake arrives while
        // still in RENDER, so it never reaches this test.
        if (vblank_pulse) begin
          state_next = ST_SWAP;
        end
      end
      ST_SWAP: begin
        state_next = ST_CLEAR;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  assign clr_m_buffer = ~active_buffer;
  assign clr_m_color  = CLEAR_COLOR;
  assign clr_m_depth  = CLEAR_DEPTH;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler
//   Bench for frame_scheduler built with PIXEL_COUNT=16 and ADDR_WIDTH=4.
//   A directed vector table covers reset, the first clear pass and the first
//   swap. Hand-written sequences and randomized traffic follow, checked
//   against a pass-level reference model.
module tb_frame_scheduler;

  localparam int unsigned PIX = 16;

  logic        clk;
  logic        rstn;
  logic        fev;
  logic        fready;
  logic        vbl;
  logic        render;
  logic        active;
  logic        cvalid;
  logic        cready;
  logic [3:0]  caddr;
  logic        cbuf;
  logic [11:0] ccolor;
  logic [15:0] cdepth;
  logic [15:0] fcount;
  logic        busy;

  frame_scheduler #(
    .PIXEL_COUNT (16),
    .ADDR_WIDTH  (4)
  ) dut (
    .clk_system      (clk),
    .rstn_system     (rstn),
    .frame_end_valid (fev),
    .frame_end_ready (fready),
    .vblank_pulse    (vbl),
    .render_enable   (render),
    .active_buffer   (active),
    .clr_m_valid     (cvalid),
    .clr_m_ready     (cready),
    .clr_m_addr      (caddr),
    .clr_m_buffer    (cbuf),
    .clr_m_color     (ccolor),
    .clr_m_depth     (cdepth),
    .frame_count     (fcount),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  addr;
    logic        render;
    logic        fready;
    logic        active;
    logic        buffer;
    logic [15:0] count;
    logic        busy;
  } outs_t;

  typedef struct {
    logic  rstn;
    logic  fev;
    logic  vbl;
    logic  rdy;
    outs_t exp;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Pass-level reference model: tracks pixels left to clear and which phase
  // of the frame cycle the scheduler is in.
  bit          m_init;
  int unsigned m_left;
  bit          m_rendering;
  bit          m_waiting;
  bit          m_swapping;
  int unsigned m_swaps;
  logic [15:0] m_count;

  function automatic outs_t mk(input logic v, input logic [3:0] a, input logic r,
                               input logic act, input logic b,
                               input logic [15:0] cnt, input logic bz);
    outs_t o;
    o.valid  = v;
    o.addr   = a;
    o.render = r;
    o.fready = r;
    o.active = act;
    o.buffer = b;
    o.count  = cnt;
    o.busy   = bz;
    return o;
  endfunction

  function automatic outs_t model_outs();
    outs_t o;
    o.valid  = (m_left > 0);
    o.addr   = (m_left > 0) ? 4'(PIX - m_left) : 4'd0;
    o.render = m_rendering;
    o.fready = m_rendering;
    o.active = m_swaps[0];
    o.buffer = ~m_swaps[0];
    o.count  = m_count;
    o.busy   = !m_rendering;
    return o;
  endfunction

  task automatic model_step(input logic r, input logic f, input logic v, input logic c);
    if (!r) begin
      m_init = 1; m_left = 0; m_rendering = 0; m_waiting = 0; m_swapping = 0;
      m_swaps = 0; m_count = 16'h0000;
    end else if (m_init) begin
      m_init = 0;
      m_left = PIX;
    end else if (m_left > 0) begin
      if (c) begin
        m_left = m_left - 1;
        if (m_left == 0) m_rendering = 1;
      end
    end else if (m_rendering) begin
      if (f) begin m_rendering = 0; m_waiting = 1; end
    end else if (m_waiting) begin
      if (v) begin m_waiting = 0; m_swapping = 1; end
    end else if (m_swapping) begin
      m_swapping = 0;
      m_swaps    = m_swaps + 1;
      m_count    = m_count + 16'd1;
      m_left     = PIX;
    end
  endtask

  task automatic chk(input string tag, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h @%0t", tag, field, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input outs_t e);
    chk(tag, "clr_m_valid",     32'(cvalid), 32'(e.valid));
    chk(tag, "clr_m_addr",      32'(caddr),  32'(e.addr));
    chk(tag, "render_enable",   32'(render), 32'(e.render));
    chk(tag, "frame_end_ready", 32'(fready), 32'(e.fready));
    chk(tag, "active_buffer",   32'(active), 32'(e.active));
    chk(tag, "clr_m_buffer",    32'(cbuf),   32'(e.buffer));
    chk(tag, "frame_count",     32'(fcount), 32'(e.count));
    chk(tag, "busy",            32'(busy),   32'(e.busy));
    chk(tag, "clr_m_color",     32'(ccolor), 32'h000);
    chk(tag, "clr_m_depth",     32'(cdepth), 32'hFFFF);
  endtask

  // mode 0: no comparison, 1: compare against e, 2: compare against model
  task automatic cycle(input logic r, input logic f, input logic v, input logic c,
                       input int mode, input outs_t e, input string tag);
    rstn = r; fev = f; vbl = v; cready = c;
    @(negedge clk);
    if (mode == 1) compare(tag, e);
    else if (mode == 2) compare(tag, model_outs());
    @(posedge clk);
    model_step(r, f, v, c);
    #1;
  endtask

  vec_t  tbl[24];
  outs_t none;

  initial begin
    none = mk(0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0; fev = 1'b0; vbl = 1'b0; cready = 1'b0;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, mk(0, 4'd0, 0, 0, 1, 16'd0, 1)};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, mk(0, 4'd0, 0, 0, 1, 16'd0, 1)};
    for (int i = 0; i < 16; i++)
      tbl[2+i] = '{1'b1, 1'b0, 1'b0, 1'b1, mk(1, 4'(i), 0, 0, 1, 16'd0, 1)};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b1, mk(0, 4'd0, 1, 0, 1, 16'd0, 0)};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 1'b1, mk(0, 4'd0, 1, 0, 1, 16'd0, 0)};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b1, mk(0, 4'd0, 0, 0, 1, 16'd0, 1)};
    tbl[21] = '{1'b1, 1'b0, 1'b1, 1'b1, mk(0, 4'd0, 0, 0, 1, 16'd0, 1)};
    tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b1, mk(0, 4'd0, 0, 0, 1, 16'd0, 1)};
    tbl[23] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1, 4'd0, 0, 1, 0, 16'd1, 1)};

    cycle(0, 0, 0, 0, 0, none, "prereset");
    cycle(0, 0, 0, 0, 0, none, "prereset");
    for (int i = 0; i < 24; i++) begin
      cycle(tbl[i].rstn, tbl[i].fev, tbl[i].vbl, tbl[i].rdy, 1, tbl[i].exp,
            $sformatf("vec%0d", i));
    end

    // Backpressure on the clear of buffer 0
    for (int i = 0; i < 200 && !m_rendering; i++)
      cycle(1, 0, 0, 1'($urandom_range(0, 1)), 2, none, "backpressure");
    chk("backpressure", "reached_render", 32'(m_rendering), 32'd1);

    // vblank coincident with the frame-end handshake is ignored
    cycle(1, 1, 1, 1, 2, none, "coincident");
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 2, none, "coincident_wait");
    chk("coincident", "no_swap", 32'(active), 32'd1);
    cycle(1, 0, 1, 1, 2, none, "coincident_vbl");
    cycle(1, 0, 0, 1, 2, none, "coincident_swap");
    cycle(1, 0, 0, 1, 2, none, "coincident_clear");
    chk("coincident", "swapped", 32'(active), 32'd0);

    // frame_end_valid held through the clear: not acknowledged until RENDER
    for (int i = 0; i < 40 && !m_rendering; i++)
      cycle(1, 1, 0, 1, 2, none, "fev_in_clear");
    cycle(1, 1, 0, 1, 2, none, "fev_accept");

    // vblank 5 cycles after the handshake, swap visible 2 cycles later
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, 2, none, "frame_wait");
    cycle(1, 0, 1, 1, 2, none, "frame_vbl");
    cycle(1, 0, 0, 1, 2, none, "frame_swap");
    cycle(1, 0, 0, 0, 2, none, "frame_clear");
    chk("full_frame", "active_buffer", 32'(active), 32'd1);
    chk("full_frame", "frame_count",   32'(fcount), 32'd3);
    chk("full_frame", "clr_m_buffer",  32'(cbuf),   32'd0);

    // Reset while clearing at address 7
    for (int i = 0; i < 40 && !(m_left > 0 && (PIX - m_left) == 7); i++)
      cycle(1, 0, 0, 1, 2, none, "to_addr7");
    chk("mid_reset", "at_addr7", 32'(caddr), 32'd7);
    cycle(0, 0, 0, 1, 2, none, "mid_reset");
    cycle(1, 0, 0, 1, 2, none, "mid_reset_init");
    cycle(1, 0, 0, 1, 2, none, "mid_reset_addr0");
    chk("mid_reset", "active_buffer", 32'(active), 32'd0);
    chk("mid_reset", "frame_count",   32'(fcount), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cycle(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 2, none, "random");
    end

    // Counter wrap with a forced starting value
    for (int i = 0; i < 200 && !m_rendering; i++) begin
      cycle(1, 0, m_waiting, 1, 2, none, "to_render");
    end
    chk("wrap", "in_render", 32'(render), 32'd1);
    force dut.frame_count = 16'hFFFE;
    m_count = 16'hFFFE;
    cycle(1, 0, 0, 1, 2, none, "wrap_force");
    release dut.frame_count;
    for (int f = 0; f < 2; f++) begin
      cycle(1, 1, 0, 1, 2, none, "wrap_fe");
      for (int i = 0; i < 60 && !m_rendering; i++)
        cycle(1, 0, m_waiting, 1, 2, none, "wrap_run");
      chk("wrap", "count_step", 32'(fcount), (f == 0) ? 32'hFFFF : 32'h0000);
      chk("wrap", "parity", 32'(active), 32'(m_swaps[0]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
